// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Definitions shared by the CPU front end and the execute stage.
//   - aaa operation codes and bbb addressing-mode codes for cc=01 opcodes
//   - fetch_state_t: front-end sequencer states
//   - VEC_ADDR_DEFAULT: location of the reset vector low byte
//   - f_operand_len: operand byte count for a cc=01 addressing mode
// -----------------------------------------------------------------------------
package cpu_pkg;

  // aaa field (opcode[7:5]) for the cc=01 group
  localparam logic [2:0] OP_ORA = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_EOR = 3'b010;
  localparam logic [2:0] OP_ADC = 3'b011;
  localparam logic [2:0] OP_STA = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_CMP = 3'b110;
  localparam logic [2:0] OP_SBC = 3'b111;

  // bbb field (opcode[4:2]) addressing modes for the cc=01 group
  localparam logic [2:0] AM_IZX = 3'b000;
  localparam logic [2:0] AM_ZP  = 3'b001;
  localparam logic [2:0] AM_IMM = 3'b010;
  localparam logic [2:0] AM_ABS = 3'b011;
  localparam logic [2:0] AM_IZY = 3'b100;
  localparam logic [2:0] AM_ZPX = 3'b101;
  localparam logic [2:0] AM_ABY = 3'b110;
  localparam logic [2:0] AM_ABX = 3'b111;

  localparam logic [1:0] CC_GROUP1 = 2'b01;

  localparam logic [15:0] VEC_ADDR_DEFAULT = 16'hFFFC;

  typedef enum logic [2:0] {
    VEC_LO   = 3'd0,
    VEC_HI   = 3'd1,
    FETCH_OP = 3'd2,
    FETCH_LO = 3'd3,
    FETCH_HI = 3'd4,
    ISSUE    = 3'd5
  } fetch_state_t;

  // Absolute and absolute-indexed modes carry a 16-bit operand; every other
  // cc=01 mode carries a single byte.
  function automatic logic [1:0] f_operand_len(input logic [2:0] bbb);
    logic [1:0] len;
    case (bbb)
      AM_ABS, AM_ABY, AM_ABX: len = 2'd2;
      default:                len = 2'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/fetch_decode_if.sv
// -----------------------------------------------------------------------------
// fetch_decode_if
//   Bundles the CPU byte bus, the instruction hand-off to the execute stage
//   and the execute-stage PC redirect.
//   master : the fetch/decode front end
//   slave  : memory + execute stage side
//   Bus      : rdy, d_in, addr, rd
//   Hand-off : instr_valid, instr_ready, opcode, op_aaa/bbb/cc, operand,
//              n_bytes, instr_pc, unsupported
//   Redirect : redirect, redirect_pc
// -----------------------------------------------------------------------------
interface fetch_decode_if;
  logic        rdy;
  logic [7:0]  d_in;
  logic [15:0] addr;
  logic        rd;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  opcode;
  logic [2:0]  op_aaa;
  logic [2:0]  op_bbb;
  logic [1:0]  op_cc;
  logic [15:0] operand;
  logic [1:0]  n_bytes;
  logic [15:0] instr_pc;
  logic        unsupported;
  logic        redirect;
  logic [15:0] redirect_pc;

  modport master (
    input  rdy, d_in, instr_ready, redirect, redirect_pc,
    output addr, rd, instr_valid, opcode, op_aaa, op_bbb, op_cc,
           operand, n_bytes, instr_pc, unsupported
  );

  modport slave (
    output rdy, d_in, instr_ready, redirect, redirect_pc,
    input  addr, rd, instr_valid, opcode, op_aaa, op_bbb, op_cc,
           operand, n_bytes, instr_pc, unsupported
  );
endinterface

// File: rtl/op_len_decode.sv
// -----------------------------------------------------------------------------
// op_len_decode
//   Purely combinational opcode classifier, shared with the execute stage.
//   opcode      in  8  raw opcode byte
//   operand_len out 2  operand bytes following the opcode (0..2)
//   unsupported out 1  opcode outside the cc=01 group, or STA immediate
// -----------------------------------------------------------------------------
module op_len_decode
  import cpu_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [1:0] operand_len,
  output logic       unsupported
);

  logic [2:0] w_aaa;
  logic [2:0] w_bbb;
  logic [1:0] w_cc;

  assign w_aaa = opcode[7:5];
  assign w_bbb = opcode[4:2];
  assign w_cc  = opcode[1:0];

  always_comb begin
    operand_len = 2'd0;
    unsupported = 1'b1;
    if (w_cc == CC_GROUP1) begin
      operand_len = f_operand_len(w_bbb);
      // STA #imm would store into the instruction stream: not a real opcode
      unsupported = (w_aaa == OP_STA) && (w_bbb == AM_IMM);
    end
  end

endmodule

// File: rtl/fetch_decode.sv
// -----------------------------------------------------------------------------
// fetch_decode
//   Instruction fetch/decode front end. Loads the PC from the reset vector,
//   reads opcode + operand bytes over the byte bus and presents one complete
//   decoded instruction at a time to the execute stage.
//   clk  in  system clock, rising edge
//   rst  in  asynchronous active-low reset
//   bus  fetch_decode_if.master (byte bus, instruction hand-off, redirect)
//   VEC_ADDR: address of the reset vector low byte (high byte at +1)
// -----------------------------------------------------------------------------
module fetch_decode
  import cpu_pkg::*;
#(
  parameter logic [15:0] VEC_ADDR = VEC_ADDR_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  fetch_decode_if.master bus
);

  fetch_state_t r_state, w_state;
  logic [15:0]  r_pc, w_pc;
  logic [7:0]   r_opcode, w_opcode;
  logic [15:0]  r_operand, w_operand;
  logic [15:0]  r_instr_pc, w_instr_pc;
  logic [1:0]   r_n_bytes, w_n_bytes;
  logic         r_unsup, w_unsup;

  logic [1:0]   w_dec_len;
  logic         w_dec_unsup;

  // Decode straight off the bus so the length is known in FETCH_OP itself.
  op_len_decode u_op_len_decode (
    .opcode      (bus.d_in),
    .operand_len (w_dec_len),
    .unsupported (w_dec_unsup)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= VEC_LO;
      r_pc       <= 16'h0000;
      r_opcode   <= 8'h00;
      r_operand  <= 16'h0000;
      r_instr_pc <= 16'h0000;
      r_n_bytes  <= 2'd0;
      r_unsup    <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_pc       <= w_pc;
      r_opcode   <= w_opcode;
      r_operand  <= w_operand;
      r_instr_pc <= w_instr_pc;
      r_n_bytes  <= w_n_bytes;
      r_unsup    <= w_unsup;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_pc       = r_pc;
    w_opcode   = r_opcode;
    w_operand  = r_operand;
    w_instr_pc = r_instr_pc;
    w_n_bytes  = r_n_bytes;
    w_unsup    = r_unsup;

    // rdy low freezes everything, including handshake acceptance
    if (bus.rdy) begin
      if (bus.redirect && (r_state != VEC_LO) && (r_state != VEC_HI)) begin
        // Redirect beats any partial fetch and any concurrent handshake;
        // the latched fields are left alone since instr_valid drops anyway.
        w_pc    = bus.redirect_pc;
        w_state = FETCH_OP;
      end else begin
        case (r_state)
          VEC_LO: begin
            w_pc[7:0] = bus.d_in;
            w_state   = VEC_HI;
          end
          VEC_HI: begin
            w_pc[15:8] = bus.d_in;
            w_state    = FETCH_OP;
          end
          FETCH_OP: begin
            w_opcode   = bus.d_in;
            w_instr_pc = r_pc;
            w_pc       = r_pc + 16'd1;
            w_operand  = 16'h0000;
            w_n_bytes  = w_dec_len + 2'd1;
            w_unsup    = w_dec_unsup;
            w_state    = (w_dec_len == 2'd0) ? ISSUE : FETCH_LO;
          end
          FETCH_LO: begin
            w_operand[7:0] = bus.d_in;
            w_pc           = r_pc + 16'd1;
            w_state        = (r_n_bytes == 2'd3) ? FETCH_HI : ISSUE;
          end
          FETCH_HI: begin
            w_operand[15:8] = bus.d_in;
            w_pc            = r_pc + 16'd1;
            w_state         = ISSUE;
          end
          ISSUE: begin
            if (bus.instr_ready) w_state = FETCH_OP;
          end
          default: w_state = VEC_LO;
        endcase
      end
    end
  end

  always_comb begin
    case (r_state)
      VEC_LO:  bus.addr = VEC_ADDR;
      VEC_HI:  bus.addr = VEC_ADDR + 16'd1;
      default: bus.addr = r_pc;
    endcase
  end

  // rd is gated by the reset itself so it is low for the whole reset pulse.
  assign bus.rd          = rst && (r_state != ISSUE);
  assign bus.instr_valid = (r_state == ISSUE);
  assign bus.opcode      = r_opcode;
  assign bus.op_aaa      = r_opcode[7:5];
  assign bus.op_bbb      = r_opcode[4:2];
  assign bus.op_cc       = r_opcode[1:0];
  assign bus.operand     = r_operand;
  assign bus.n_bytes     = r_n_bytes;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.unsupported = r_unsup;

endmodule

// File: doc/fetch_decode.md
Name: fetch_decode

Overview:
Instruction fetch/decode front end for the 6502-compatible CPU core.
- Loads the PC from the reset vector and owns the program counter.
- Reads the opcode and its operand bytes over the CPU byte bus.
- Decodes aaa/bbb/cc fields and operand length.
- Hands one complete instruction at a time to the execute stage over a valid/ready handshake.
- Sits between the memory bus and the ALU/execute datapath in cpu.

Parameters:
- VEC_ADDR, 16'hFFFC: address of the reset vector low byte; the high byte is at VEC_ADDR+1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  bus ready; low stalls all state, PC and bus outputs (DMA/stall).
- d_in  in  8  read data; valid in the same cycle as addr, sampled at the rising edge when rdy=1.
- addr  out  16  bus address for the current fetch.
- rd  out  1  read strobe; high in every fetch state.
- instr_valid  out  1  decoded instruction available.
- instr_ready  in  1  execute stage accepts the instruction.
- opcode  out  8  raw opcode byte.
- op_aaa  out  3  opcode[7:5].
- op_bbb  out  3  opcode[4:2].
- op_cc  out  2  opcode[1:0].
- operand  out  16  {hi,lo}; hi=0 for 1-operand instructions; 0 for 0-operand instructions.
- n_bytes  out  2  total instruction length, 1 to 3.
- instr_pc  out  16  address of the opcode byte.
- unsupported  out  1  cc!=01, or STA immediate (aaa=100, bbb=010).
- redirect  in  1  execute-stage PC load (jump/branch taken).
- redirect_pc  in  16  new PC.

Behaviour:
- States: VEC_LO, VEC_HI, FETCH_OP, FETCH_LO, FETCH_HI, ISSUE.

Reset (rst=0, asynchronous):
- state=VEC_LO, pc=0, addr=VEC_ADDR.
- rd=0 while reset is asserted.
- instr_valid=0; opcode, operand, instr_pc, n_bytes, unsupported all 0.
- Reset mid-fetch discards everything.

addr mux:
- VEC_LO: VEC_ADDR.
- VEC_HI: VEC_ADDR+1.
- Fetch states: pc.
- ISSUE: pc, with rd=0.

Rules below apply only on clock edges with rdy=1. With rdy=0 nothing changes, including handshake acceptance: instr_ready is ignored.

State transitions:
- VEC_LO: latch pc[7:0]=d_in, go to VEC_HI.
- VEC_HI: latch pc[15:8]=d_in, go to FETCH_OP.
- FETCH_OP:
  - Latch opcode=d_in and instr_pc=pc; pc+=1.
  - Operand length from the cc=01 table:
    - 1 byte: bbb 000, 001, 010, 100, 101.
    - 2 bytes: bbb 011, 110, 111.
    - cc!=01: 0 operand bytes, with unsupported=1.
  - Length 0 goes to ISSUE; otherwise go to FETCH_LO.
- FETCH_LO: latch operand[7:0], pc+=1. Go to FETCH_HI if length is 2, else ISSUE.
- FETCH_HI: latch operand[15:8], pc+=1, go to ISSUE.
- ISSUE:
  - instr_valid=1; outputs are stable while waiting.
  - On instr_valid & instr_ready: go to FETCH_OP; instr_valid=0 next cycle.
  - Minimum gap between issues: 1 + length cycles (1 to 3).

PC arithmetic:
- PC is 16-bit and wraps FFFF->0000.
- An operand fetch straddling FFFF continues at 0000.

Redirect:
- Highest priority in FETCH_OP, FETCH_LO, FETCH_HI and ISSUE.
- Effect: pc=redirect_pc, state=FETCH_OP, instr_valid=0 next cycle, and any partial instruction is discarded.
- Redirect in the same cycle as a handshake: the instruction counts as accepted and the redirect wins.
- Redirect is ignored in VEC_LO and VEC_HI.

Decomposition:
Shared package cpu_pkg holds:
- aaa opcode constants: ORA, AND, EOR, ADC, STA, LDA, CMP, SBC.
- bbb addressing constants: IZX=000, ZP=001, IMM=010, ABS=011, IZY=100, ZPX=101, ABY=110, ABX=111.
- The fetch_state_t enum.
- The vector default.

One combinational sub-module, op_len_decode:
- Input: opcode.
- Outputs: operand byte count (0 to 2) and unsupported.
- Reused later by the execute stage.

Test Plan:
1. Reset vector: mem[FFFC]=00, mem[FFFD]=80, rst released → bus reads FFFC, FFFD, then addr=8000 in the third cycle.
2. Immediate: mem[8000]=A9, mem[8001]=42 → ISSUE with opcode=A9, aaa=101, bbb=010, operand=0042, n_bytes=2, instr_pc=8000. Next fetch address is 8002.
3. Absolute with backpressure: 6D 34 12 at 8002, instr_ready held low 4 cycles → instr_valid high with operand=1234 stable for all 4 cycles. After ready, the fetch resumes at 8005.
4. Unsupported and wrap: pc=FFFF, opcode EA → unsupported=1, n_bytes=1, next fetch at 0000. Separately, 0D 00 20 placed at FFFE → operand high byte read from 0000.
5. Redirect during FETCH_LO, redirect_pc=C000 → no instr_valid for the partial instruction, and the next addr is C000. Redirect concurrent with a handshake → exactly one instruction accepted.
6. rdy low for 3 cycles during FETCH_HI, and async rst asserted mid-FETCH_LO → state and addr frozen during the rdy stall. The reset immediately zeroes the outputs and restarts at FFFC.
